// File: rtl/anim_pkg.sv
// Shared types and defaults for the animation pipeline (frame_sequencer,
// clear_screen, line_drawer and the wrap_add helper).
package anim_pkg;

  // Pixel coordinate on the VGA frame buffer. 11 bits covers 0..2047.
  typedef logic [10:0] coord_t;

  localparam int H_RES_DEF = 640;
  localparam int V_RES_DEF = 480;

  // Frame sequencer states. Each *_ARM state exists because the engines'
  // done flags are still high from the previous job in the cycle after a
  // start pulse.
  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CLR_GO,
    ST_CLR_ARM,
    ST_CLR_WAIT,
    ST_FETCH,
    ST_LOAD,
    ST_LN_GO,
    ST_LN_ARM,
    ST_LN_WAIT,
    ST_DONE
  } seq_state_e;

endpackage

// File: rtl/wrap_add.sv
// wrap_add: modular coordinate offset for one screen axis.
//   result = (min(coord, MOD-1) + off) wrapped once into [0, MOD).
// Valid as long as off < MOD, which keeps the 12-bit sum below 2*MOD, so a
// single conditional subtract replaces a divider.
// Ports:
//   coord   in  11  raw coordinate (may exceed the screen)
//   off     in  11  offset, must be < MOD
//   result  out 11  wrapped coordinate
module wrap_add
  import anim_pkg::*;
#(
  parameter int MOD = H_RES_DEF
) (
  input  logic [10:0] coord,
  input  logic [10:0] off,
  output logic [10:0] result
);

  coord_t      clamped;
  logic [11:0] sum;

  // NOTE: every variable driven here gets a value on every path; a missed
  // branch in a combinational block would infer a latch.
  always_comb begin
    clamped = (coord >= coord_t'(MOD)) ? coord_t'(MOD - 1) : coord;
    sum     = {1'b0, clamped} + {1'b0, off};
    result  = (sum >= 12'(MOD)) ? coord_t'(sum - 12'(MOD)) : coord_t'(sum);
  end

endmodule

// File: rtl/frame_sequencer.sv
// frame_sequencer: per-frame scheduler for clear_screen and line_drawer.
// On a frame tick it clears the screen, then walks the segment table issuing
// one line at a time with a running (x,y) offset that advances every frame.
// It owns the single pixel write port to the frame buffer.
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   frame_tick, enable         frame request pulse, frame start gate
//   seg_addr / seg_x0..seg_y1  segment table address, data one cycle later
//   clear_start/clear_done     handshake with clear_screen
//   clear_x, clear_y           clear_screen pixel address
//   line_start/line_done       handshake with line_drawer
//   lines_x, lines_y           line_drawer pixel address
//   x0, y0, x1, y1             offset endpoints to line_drawer
//   x, y, color                pixel write port (color 0 = clear, 1 = line)
//   busy, frame_done, overrun  status: not idle, frame finished, tick dropped
module frame_sequencer
  import anim_pkg::*;
#(
  parameter  int N_SEGS = 4,
  parameter  int H_RES  = H_RES_DEF,
  parameter  int V_RES  = V_RES_DEF,
  parameter  int X_STEP = 20,
  parameter  int Y_STEP = 10,
  localparam int AW     = (N_SEGS > 1) ? $clog2(N_SEGS) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          frame_tick,
  input  logic          enable,
  output logic [AW-1:0] seg_addr,
  input  logic [10:0]   seg_x0,
  input  logic [10:0]   seg_y0,
  input  logic [10:0]   seg_x1,
  input  logic [10:0]   seg_y1,
  output logic          clear_start,
  input  logic          clear_done,
  input  logic [10:0]   clear_x,
  input  logic [10:0]   clear_y,
  output logic          line_start,
  input  logic          line_done,
  input  logic [10:0]   lines_x,
  input  logic [10:0]   lines_y,
  output logic [10:0]   x0,
  output logic [10:0]   y0,
  output logic [10:0]   x1,
  output logic [10:0]   y1,
  output logic [10:0]   x,
  output logic [10:0]   y,
  output logic          color,
  output logic          busy,
  output logic          frame_done,
  output logic          overrun
);

  seq_state_e state, state_nxt;

  coord_t x_off, y_off;
  coord_t x_off_nxt, y_off_nxt;
  coord_t adj_x0, adj_y0, adj_x1, adj_y1;
  logic   last_seg;

  // Offset-adjusted endpoints of the segment currently on the table bus.
  wrap_add #(.MOD(H_RES)) u_wrap_x0 (.coord(seg_x0), .off(x_off), .result(adj_x0));
  wrap_add #(.MOD(V_RES)) u_wrap_y0 (.coord(seg_y0), .off(y_off), .result(adj_y0));
  wrap_add #(.MOD(H_RES)) u_wrap_x1 (.coord(seg_x1), .off(x_off), .result(adj_x1));
  wrap_add #(.MOD(V_RES)) u_wrap_y1 (.coord(seg_y1), .off(y_off), .result(adj_y1));

  // Offset advance: the offsets are always < modulus, so the clamp is inert
  // and the same wrap-once adder gives (off + STEP) mod RES.
  wrap_add #(.MOD(H_RES)) u_wrap_xoff (
    .coord(x_off), .off(coord_t'(X_STEP)), .result(x_off_nxt)
  );
  wrap_add #(.MOD(V_RES)) u_wrap_yoff (
    .coord(y_off), .off(coord_t'(Y_STEP)), .result(y_off_nxt)
  );

  assign last_seg = (seg_addr == AW'(N_SEGS - 1));
  assign busy     = (state != ST_IDLE);

  // Pixel port: engines never run at the same time, so color doubles as the
  // owner select for the address mux.
  assign x = color ? lines_x : clear_x;
  assign y = color ? lines_y : clear_y;

  // NOTE: state and datapath registers use non-blocking assignments so every
  // flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    clear_start = 1'b0;
    line_start  = 1'b0;
    frame_done  = 1'b0;
    unique case (state)
      ST_IDLE:     if (frame_tick && enable) state_nxt = ST_CLR_GO;
      ST_CLR_GO: begin
        clear_start = 1'b1;
        state_nxt   = ST_CLR_ARM;
      end
      ST_CLR_ARM:  state_nxt = ST_CLR_WAIT;
      ST_CLR_WAIT: if (clear_done) state_nxt = ST_FETCH;
      ST_FETCH:    state_nxt = ST_LOAD;
      ST_LOAD:     state_nxt = ST_LN_GO;
      ST_LN_GO: begin
        line_start = 1'b1;
        state_nxt  = ST_LN_ARM;
      end
      ST_LN_ARM:   state_nxt = ST_LN_WAIT;
      ST_LN_WAIT:  if (line_done) state_nxt = last_seg ? ST_DONE : ST_FETCH;
      ST_DONE: begin
        frame_done = 1'b1;
        state_nxt  = ST_IDLE;
      end
      default:     state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg_addr <= '0;
      x0       <= '0;
      y0       <= '0;
      x1       <= '0;
      y1       <= '0;
      x_off    <= '0;
      y_off    <= '0;
      color    <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      // Any tick that arrives while a frame is in flight (DONE included)
      // is dropped and reported one cycle later.
      overrun <= frame_tick && busy;
      unique case (state)
        ST_CLR_GO:   color <= 1'b0;
        ST_CLR_WAIT: if (clear_done) seg_addr <= '0;
        ST_LOAD: begin
          x0    <= adj_x0;
          y0    <= adj_y0;
          x1    <= adj_x1;
          y1    <= adj_y1;
          color <= 1'b1;
        end
        ST_LN_WAIT:  if (line_done && !last_seg) seg_addr <= seg_addr + AW'(1);
        ST_DONE: begin
          x_off    <= x_off_nxt;
          y_off    <= y_off_nxt;
          seg_addr <= '0;
          color    <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_sequencer.sv
// Self-checking bench for frame_sequencer: table vectors for the first
// frames after reset, hand-written overrun / enable / reset sequences, and
// randomized segment tables checked against a modular-arithmetic model.
module tb_frame_sequencer;
  import anim_pkg::*;

  localparam int N_SEGS = 4;
  localparam int H_RES  = 640;
  localparam int V_RES  = 480;
  localparam int X_STEP = 20;
  localparam int Y_STEP = 10;
  localparam int AW     = 2;

  typedef struct packed {
    coord_t x0;
    coord_t y0;
    coord_t x1;
    coord_t y1;
  } seg_t;

  typedef struct {
    seg_t seg;
    seg_t exp;
  } vec_t;

  typedef struct {
    int            cyc;
    logic [AW-1:0] addr;
    seg_t          ep;
  } obs_t;

  logic          clk = 1'b0;
  logic          reset, frame_tick, enable;
  logic [AW-1:0] seg_addr;
  logic [10:0]   seg_x0, seg_y0, seg_x1, seg_y1;
  logic          clear_start, clear_done, line_start, line_done;
  logic [10:0]   clear_x, clear_y, lines_x, lines_y;
  logic [10:0]   x0, y0, x1, y1, x, y;
  logic          color, busy, frame_done, overrun;

  frame_sequencer #(
    .N_SEGS(N_SEGS), .H_RES(H_RES), .V_RES(V_RES), .X_STEP(X_STEP), .Y_STEP(Y_STEP)
  ) dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .enable(enable),
    .seg_addr(seg_addr), .seg_x0(seg_x0), .seg_y0(seg_y0), .seg_x1(seg_x1), .seg_y1(seg_y1),
    .clear_start(clear_start), .clear_done(clear_done), .clear_x(clear_x), .clear_y(clear_y),
    .line_start(line_start), .line_done(line_done), .lines_x(lines_x), .lines_y(lines_y),
    .x0(x0), .y0(y0), .x1(x1), .y1(y1), .x(x), .y(y), .color(color),
    .busy(busy), .frame_done(frame_done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass = 0;
  int n_checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  seg_t tbl [N_SEGS];
  int   k_frames = 0;   // frames completed since the last reset

  function automatic coord_t ref_wrap(input int c, input int off, input int m);
    int cc;
    cc = (c >= m) ? m - 1 : c;
    return coord_t'((cc + off) % m);
  endfunction

  function automatic seg_t ref_seg(input seg_t s, input int k);
    int xo, yo;
    seg_t r;
    xo = (k * X_STEP) % H_RES;
    yo = (k * Y_STEP) % V_RES;
    r.x0 = ref_wrap(int'(s.x0), xo, H_RES);
    r.y0 = ref_wrap(int'(s.y0), yo, V_RES);
    r.x1 = ref_wrap(int'(s.x1), xo, H_RES);
    r.y1 = ref_wrap(int'(s.y1), yo, V_RES);
    return r;
  endfunction

  function automatic seg_t mk(input int a, input int b, input int c, input int d);
    seg_t s;
    s.x0 = coord_t'(a); s.y0 = coord_t'(b); s.x1 = coord_t'(c); s.y1 = coord_t'(d);
    return s;
  endfunction

  task automatic load_square();
    tbl[0] = mk(200, 200, 200, 400);
    tbl[1] = mk(200, 400, 400, 400);
    tbl[2] = mk(400, 400, 400, 200);
    tbl[3] = mk(400, 200, 200, 200);
  endtask

  // ---------------- environment models ----------------
  // Segment table: data reflects the address seen one cycle earlier.
  logic [AW-1:0] rom_addr_q = '0;
  initial begin
    forever begin
      @(negedge clk);
      {seg_x0, seg_y0, seg_x1, seg_y1} = tbl[rom_addr_q];
      rom_addr_q = seg_addr;
    end
  end

  int clr_done_cyc = 0;
  initial begin
    clear_done = 1'b1;
    forever begin
      @(negedge clk);
      if (clear_start) begin
        clear_done = 1'b0;
        repeat (5) @(negedge clk);
        clear_done   = 1'b1;
        clr_done_cyc = cyc;
      end
    end
  end

  initial begin
    line_done = 1'b1;
    forever begin
      @(negedge clk);
      if (line_start) begin
        line_done = 1'b0;
        repeat (3) @(negedge clk);
        line_done = 1'b1;
      end
    end
  end

  // Monitor: event counters, pixel-mux checks, per-line endpoint capture.
  int   n_clr = 0, n_line = 0, n_fd = 0, n_ovr = 0;
  obs_t obs_q[$];
  always @(negedge clk) begin
    if (!reset) begin
      if (clear_start) begin
        n_clr++;
        check("mux_clear", 64'({x, y}), 64'({clear_x, clear_y}));
      end
      if (line_start) begin
        n_line++;
        check("mux_line", 64'({x, y}), 64'({lines_x, lines_y}));
        obs_q.push_back('{cyc: cyc, addr: seg_addr, ep: seg_t'({x0, y0, x1, y1})});
      end
      if (frame_done) n_fd++;
      if (overrun)    n_ovr++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // mode: 0 plain, 1 tick during LN_WAIT, 2 tick during DONE, 3 enable drop
  task automatic run_frame(input string tag, input int mode);
    int  c0, l0, f0, o0, budget;
    bit  got;
    c0 = n_clr; l0 = n_line; f0 = n_fd; o0 = n_ovr;
    obs_q.delete();
    clear_x = 11'($urandom_range(0, 2047));
    clear_y = 11'($urandom_range(0, 2047));
    lines_x = ~clear_x;
    lines_y = ~clear_y;
    @(negedge clk);
    enable = 1'b1; frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    check({tag, "/tick_to_clr"}, 64'(clear_start), 64'(1));
    if (mode == 3) enable = 1'b0;
    if (mode == 1) begin
      budget = 200;
      while (!line_start && budget > 0) begin @(negedge clk); budget--; end
      check({tag, "/line_start_seen"}, 64'(budget > 0), 64'(1));
      @(negedge clk);
      @(negedge clk);
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
      check({tag, "/overrun_ln_wait"}, 64'(overrun), 64'(1));
    end
    budget = 2000; got = 1'b0;
    while (budget > 0 && !got) begin
      if (frame_done) got = 1'b1;
      else begin @(negedge clk); budget--; end
    end
    check({tag, "/frame_done_seen"}, 64'(got), 64'(1));
    if (mode == 2 && got) begin
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
      check({tag, "/overrun_done"}, 64'(overrun), 64'(1));
    end else begin
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    check({tag, "/idle_after"}, 64'(busy), 64'(0));
    check({tag, "/clear_starts"}, 64'(n_clr - c0), 64'(1));
    check({tag, "/line_starts"}, 64'(n_line - l0), 64'(N_SEGS));
    check({tag, "/frame_dones"}, 64'(n_fd - f0), 64'(1));
    check({tag, "/overruns"}, 64'(n_ovr - o0), 64'((mode == 1 || mode == 2) ? 1 : 0));
    if (obs_q.size() > 0)
      check({tag, "/clr_to_line"}, 64'(obs_q[0].cyc - clr_done_cyc), 64'(3));
    for (int i = 0; i < N_SEGS && i < obs_q.size(); i++) begin
      check($sformatf("%s/seg%0d_addr", tag, i), 64'(obs_q[i].addr), 64'(i));
      check($sformatf("%s/seg%0d_ep", tag, i), 64'(obs_q[i].ep), 64'(ref_seg(tbl[i], k_frames)));
    end
    if (got) k_frames++;
  endtask

  initial begin
    vec_t vecs [5];
    int   budget;
    bit   seen;
    int   c0;

    vecs[0] = '{seg: mk(200, 200, 200, 400), exp: mk(200, 200, 200, 400)};
    vecs[1] = '{seg: mk(200, 200, 200, 400), exp: mk(220, 210, 220, 410)};
    vecs[2] = '{seg: mk(630, 470, 700, 479), exp: mk( 30,  10,  39,  19)};
    vecs[3] = '{seg: mk(  0,   0, 639, 479), exp: mk( 60,  30,  59,  29)};
    vecs[4] = '{seg: mk(  5,   5,   5,   5), exp: mk( 85,  45,  85,  45)};

    reset = 1'b1; frame_tick = 1'b0; enable = 1'b0;
    clear_x = 11'd123; clear_y = 11'd45; lines_x = 11'd600; lines_y = 11'd300;
    load_square();
    repeat (3) @(negedge clk);
    check("reset_state",
          64'({busy, color, seg_addr, clear_start, line_start, frame_done, overrun, x0, y0, x1, y1}),
          64'(0));
    check("reset_mux", 64'({x, y}), 64'({11'd123, 11'd45}));
    reset = 1'b0;
    @(negedge clk);

    // Table-driven: consecutive frames from reset, segment 0 varied.
    for (int i = 0; i < 5; i++) begin
      load_square();
      tbl[0] = vecs[i].seg;
      run_frame($sformatf("vec%0d", i), 0);
      if (obs_q.size() > 0)
        check($sformatf("vec%0d/table", i), 64'(obs_q[0].ep), 64'(vecs[i].exp));
      else
        check($sformatf("vec%0d/table_missing", i), 64'(obs_q.size()), 64'(N_SEGS));
    end

    // enable low at tick: dropped silently.
    c0 = n_clr; seen = 1'b0;
    enable = 1'b0; frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    repeat (6) begin seen |= busy | overrun; @(negedge clk); end
    check("en0/no_activity", 64'(seen), 64'(0));
    check("en0/no_clear", 64'(n_clr - c0), 64'(0));

    // Dropped ticks while busy.
    load_square();
    run_frame("ovr_ln_wait", 1);
    run_frame("ovr_done", 2);

    // Enable falls mid-frame: frame completes, no further frame starts.
    run_frame("en_drop", 3);
    c0 = n_clr; seen = 1'b0;
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    repeat (6) begin seen |= busy; @(negedge clk); end
    check("en_drop/no_restart", 64'(n_clr - c0 + int'(seen)), 64'(0));

    // Async reset during LN_WAIT.
    load_square();
    enable = 1'b1; frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    budget = 200;
    while (!line_start && budget > 0) begin @(negedge clk); budget--; end
    check("rst_mid/line_start_seen", 64'(budget > 0), 64'(1));
    @(negedge clk);
    @(negedge clk);
    check("rst_mid/pre_color", 64'(color), 64'(1));
    #2 reset = 1'b1;
    #1 check("rst_mid/async_clear", 64'({busy, color, seg_addr, x0, y0, x1, y1}), 64'(0));
    @(negedge clk);
    reset = 1'b0;
    k_frames = 0;
    repeat (10) @(negedge clk);
    run_frame("post_rst", 0);

    // (630,470) with offsets (20,10) wraps to (10,0).
    load_square();
    tbl[0] = mk(0, 0, 630, 470);
    run_frame("wrap_both", 0);
    if (obs_q.size() > 0)
      check("wrap_630_470", 64'({obs_q[0].ep.x1, obs_q[0].ep.y1}), 64'({11'd10, 11'd0}));

    // Randomized tables, crossing the x offset wrap at frame 32.
    while (k_frames < 36) begin
      for (int i = 0; i < N_SEGS; i++) begin
        tbl[i].x0 = 11'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 2047) : $urandom_range(0, 639));
        tbl[i].y0 = 11'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 2047) : $urandom_range(0, 479));
        tbl[i].x1 = 11'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 2047) : $urandom_range(0, 639));
        tbl[i].y1 = 11'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 2047) : $urandom_range(0, 479));
      end
      if (k_frames == 31 || k_frames == 32) tbl[0].x0 = 11'd0;
      begin
        int k_now;
        k_now = k_frames;
        run_frame($sformatf("rand_k%0d", k_now), 0);
        if (k_now == 31 && obs_q.size() > 0) check("xoff_620", 64'(obs_q[0].ep.x0), 64'(620));
        if (k_now == 32 && obs_q.size() > 0) check("xoff_wrap_0", 64'(obs_q[0].ep.x0), 64'(0));
        if (k_now == k_frames) begin
          $display("FAIL rand_progress: frame %0d did not complete", k_now);
          n_checks++;
          break;
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
